// File: rtl/l2_tshr_alloc_ctrl_if.sv
// l2_tshr_alloc_ctrl_if: request handshakes, TSHR update port and status
// for the L2 TSHR write-side manager.
// Entry encoding: ENTRY_W-bit vector, bit 0 is the entry valid flag.
// The master modport is the directory pipeline side. The slave modport is
// the allocation controller.
interface l2_tshr_alloc_ctrl_if #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 8
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic               alloc_valid;
  logic [ENTRY_W-1:0] alloc_entry;
  logic               alloc_ready;
  logic [IDX_W-1:0]   alloc_index;

  logic               mod_valid;
  logic [IDX_W-1:0]   mod_index;
  logic [ENTRY_W-1:0] mod_entry;
  logic               mod_ready;

  logic               dealloc_valid;
  logic [IDX_W-1:0]   dealloc_index;
  logic               dealloc_ready;

  logic               update_en;
  logic [IDX_W-1:0]   update_index;
  logic [ENTRY_W-1:0] update_entry;

  logic [OCC_W-1:0]   occupancy;
  logic               full;
  logic               almost_full;
  logic               proto_err;
  logic [OCC_W-1:0]   peak_occ;
  logic [31:0]        stall_cnt;

  modport master (
    output alloc_valid, alloc_entry, mod_valid, mod_index, mod_entry,
           dealloc_valid, dealloc_index,
    input  alloc_ready, alloc_index, mod_ready, dealloc_ready,
           update_en, update_index, update_entry,
           occupancy, full, almost_full, proto_err, peak_occ, stall_cnt
  );

  modport slave (
    input  alloc_valid, alloc_entry, mod_valid, mod_index, mod_entry,
           dealloc_valid, dealloc_index,
    output alloc_ready, alloc_index, mod_ready, dealloc_ready,
           update_en, update_index, update_entry,
           occupancy, full, almost_full, proto_err, peak_occ, stall_cnt
  );
endinterface

// File: rtl/l2_tshr_alloc_ctrl.sv
// l2_tshr_alloc_ctrl: single owner of the L2 directory TSHR update port.
// Arbitrates dealloc > mod > alloc, picks the lowest free index from a valid
// shadow, tracks occupancy and registers one TSHR write per cycle.
// Optional feature macro: L2_TSHR_ALLOC_STATS_EN (peak_occ / stall_cnt
// counters). When it is undefined both outputs are tied to zero.
`ifndef TSHR_SIZE
`define TSHR_SIZE 4
`endif

module l2_tshr_alloc_ctrl #(
  parameter int DEPTH        = `TSHR_SIZE,
  parameter int AF_THRESHOLD = DEPTH - 1,
  parameter int ENTRY_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  l2_tshr_alloc_ctrl_if.slave    bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Lowest-numbered clear bit of the shadow (LSB priority).
  function automatic logic [IDX_W-1:0] lowest_free(input logic [DEPTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!v[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Shadow bit at a runtime index. Out-of-range indices read as invalid.
  function automatic logic shadow_bit(input logic [DEPTH-1:0] v,
                                      input logic [IDX_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (IDX_W'(i) == idx) begin
        r = v[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Shadow with the bit at idx forced to val.
  function automatic logic [DEPTH-1:0] shadow_set(input logic [DEPTH-1:0] v,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic val);
    logic [DEPTH-1:0] r;
    r = v;
    for (int i = 0; i < DEPTH; i++) begin
      if (IDX_W'(i) == idx) begin
        r[i] = val;
      end else begin
        r[i] = v[i];
      end
    end
    return r;
  endfunction

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               full_q, full_d;
  logic               af_q, af_d;
  logic               err_q, err_d;
  logic               upd_en_q, upd_en_d;
  logic [IDX_W-1:0]   upd_idx_q, upd_idx_d;
  logic [ENTRY_W-1:0] upd_entry_q, upd_entry_d;

  logic dealloc_rdy_s, mod_rdy_s, alloc_rdy_s;
  logic dealloc_go_s, mod_go_s, alloc_go_s;
  logic [IDX_W-1:0] free_idx_s;

  // Grant arbitration: one grant per cycle, dealloc > mod > alloc.
  always_comb begin
    dealloc_rdy_s = enable;
    mod_rdy_s     = enable & ~bus.dealloc_valid;
    alloc_rdy_s   = enable & ~bus.dealloc_valid & ~bus.mod_valid & ~full_q;
    dealloc_go_s  = bus.dealloc_valid & dealloc_rdy_s;
    mod_go_s      = bus.mod_valid & mod_rdy_s;
    alloc_go_s    = bus.alloc_valid & alloc_rdy_s;
    free_idx_s    = lowest_free(valid_q);
  end

  // Next-state: shadow, occupancy, sticky error and the registered TSHR write.
  always_comb begin
    valid_d     = valid_q;
    occ_d       = occ_q;
    err_d       = err_q;
    upd_en_d    = upd_en_q;
    upd_idx_d   = upd_idx_q;
    upd_entry_d = upd_entry_q;
    if (enable) begin
      upd_en_d = 1'b0;
      if (dealloc_go_s) begin
        if (shadow_bit(valid_q, bus.dealloc_index)) begin
          valid_d     = shadow_set(valid_q, bus.dealloc_index, 1'b0);
          occ_d       = occ_q - OCC_W'(1);
          upd_en_d    = 1'b1;
          upd_idx_d   = bus.dealloc_index;
          upd_entry_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end else if (mod_go_s) begin
        if (shadow_bit(valid_q, bus.mod_index)) begin
          upd_en_d    = 1'b1;
          upd_idx_d   = bus.mod_index;
          upd_entry_d = bus.mod_entry | ENTRY_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (alloc_go_s) begin
        valid_d     = shadow_set(valid_q, free_idx_s, 1'b1);
        occ_d       = occ_q + OCC_W'(1);
        upd_en_d    = 1'b1;
        upd_idx_d   = free_idx_s;
        upd_entry_d = bus.alloc_entry | ENTRY_W'(1);
      end else begin
        upd_en_d = 1'b0;
      end
    end else begin
      // Stalled: the pending write is held so l2_tshr commits it on resume.
      upd_en_d = upd_en_q;
    end
    full_d = (occ_d == OCC_W'(DEPTH));
    af_d   = (occ_d >= OCC_W'(AF_THRESHOLD));
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      af_q        <= (AF_THRESHOLD == 0);
      err_q       <= 1'b0;
      upd_en_q    <= 1'b0;
      upd_idx_q   <= '0;
      upd_entry_q <= '0;
    end else begin
      valid_q     <= valid_d;
      occ_q       <= occ_d;
      full_q      <= full_d;
      af_q        <= af_d;
      err_q       <= err_d;
      upd_en_q    <= upd_en_d;
      upd_idx_q   <= upd_idx_d;
      upd_entry_q <= upd_entry_d;
    end
  end

  assign bus.dealloc_ready = dealloc_rdy_s;
  assign bus.mod_ready     = mod_rdy_s;
  assign bus.alloc_ready   = alloc_rdy_s;
  assign bus.alloc_index   = free_idx_s;
  assign bus.update_en     = upd_en_q;
  assign bus.update_index  = upd_idx_q;
  assign bus.update_entry  = upd_entry_q;
  assign bus.occupancy     = occ_q;
  assign bus.full          = full_q;
  assign bus.almost_full   = af_q;
  assign bus.proto_err     = err_q;

`ifdef L2_TSHR_ALLOC_STATS_EN
  logic [OCC_W-1:0] peak_q, peak_d;
  logic [31:0]      stall_q, stall_d;

  // Peak occupancy tracking and saturating blocked-alloc counter.
  always_comb begin
    peak_d  = peak_q;
    stall_d = stall_q;
    if (enable) begin
      if (occ_d > peak_q) begin
        peak_d = occ_d;
      end else begin
        peak_d = peak_q;
      end
      if (bus.alloc_valid && !alloc_rdy_s && (stall_q != 32'hFFFF_FFFF)) begin
        stall_d = stall_q + 32'd1;
      end else begin
        stall_d = stall_q;
      end
    end else begin
      peak_d = peak_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_q  <= '0;
      stall_q <= 32'd0;
    end else begin
      peak_q  <= peak_d;
      stall_q <= stall_d;
    end
  end

  assign bus.peak_occ  = peak_q;
  assign bus.stall_cnt = stall_q;
`else
  assign bus.peak_occ  = '0;
  assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_l2_tshr_alloc_ctrl.sv
// tb_l2_tshr_alloc_ctrl: directed bench with an expected-write scoreboard
// for the L2 TSHR allocation controller (DEPTH = 4, 8-bit entries).
module tb_l2_tshr_alloc_ctrl;
  localparam int DEPTH   = 4;
  localparam int ENTRY_W = 8;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] entry;
  } wr_t;

  logic clk;
  logic reset;
  logic enable;
  int   checks   = 0;
  int   failures = 0;
  wr_t  exp_q[$];
  wr_t  last_wr;

  l2_tshr_alloc_ctrl_if #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) bus ();

  l2_tshr_alloc_ctrl #(.DEPTH(DEPTH), .AF_THRESHOLD(DEPTH - 1), .ENTRY_W(ENTRY_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the registered write port against the scoreboard.
  task automatic tick(input bit held);
    wr_t e;
    @(posedge clk);
    @(negedge clk);
    if (held) begin
      chk("hold_en", 64'(bus.update_en), 64'd1);
      chk("hold_idx", 64'(bus.update_index), 64'(last_wr.idx));
      chk("hold_entry", 64'(bus.update_entry), 64'(last_wr.entry));
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("upd_en", 64'(bus.update_en), 64'd1);
      chk("upd_idx", 64'(bus.update_index), 64'(e.idx));
      chk("upd_entry", 64'(bus.update_entry), 64'(e.entry));
      last_wr = e;
    end else begin
      chk("upd_idle", 64'(bus.update_en), 64'd0);
    end
  endtask

  task automatic chk_status(input string tag, input int occ, input bit full, input bit af);
    chk({tag, "_occ"}, 64'(bus.occupancy), 64'(occ));
    chk({tag, "_full"}, 64'(bus.full), 64'(full));
    chk({tag, "_af"}, 64'(bus.almost_full), 64'(af));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_upd_en"}, 64'(bus.update_en), 64'd0);
    chk({tag, "_upd_idx"}, 64'(bus.update_index), 64'd0);
    chk({tag, "_upd_entry"}, 64'(bus.update_entry), 64'd0);
    chk({tag, "_perr"}, 64'(bus.proto_err), 64'd0);
    chk({tag, "_peak"}, 64'(bus.peak_occ), 64'd0);
    chk({tag, "_stall"}, 64'(bus.stall_cnt), 64'd0);
    chk_status(tag, 0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] ent;
    clk = 1'b0;
    reset = 1'b1;
    enable = 1'b1;
    bus.alloc_valid = 1'b0;
    bus.alloc_entry = 8'h00;
    bus.mod_valid = 1'b0;
    bus.mod_index = 2'd0;
    bus.mod_entry = 8'h00;
    bus.dealloc_valid = 1'b0;
    bus.dealloc_index = 2'd0;
    last_wr = '0;
    #1;
    chk_reset_state("rst");
    @(negedge clk);
    reset = 1'b0;

    // Four back-to-back allocations get indices 0..3.
    for (int i = 0; i < 4; i++) begin
      ent = 8'hA0 + 8'(i * 2);
      bus.alloc_valid = 1'b1;
      bus.alloc_entry = ent;
      #1;
      chk("alloc_ready", 64'(bus.alloc_ready), 64'd1);
      chk("alloc_index", 64'(bus.alloc_index), 64'(i));
      exp_q.push_back('{idx: 2'(i), entry: ent | 8'h01});
      tick(1'b0);
    end
    chk_status("fill", 4, 1'b1, 1'b1);

    // Fifth alloc is blocked at full.
    #1;
    chk("alloc_full_ready", 64'(bus.alloc_ready), 64'd0);
    tick(1'b0);

    // Dealloc idx 2 together with alloc: dealloc wins.
    bus.dealloc_valid = 1'b1;
    bus.dealloc_index = 2'd2;
    bus.alloc_entry = 8'hC4;
    #1;
    chk("dual_dealloc_ready", 64'(bus.dealloc_ready), 64'd1);
    chk("dual_alloc_ready", 64'(bus.alloc_ready), 64'd0);
    exp_q.push_back('{idx: 2'd2, entry: 8'h00});
    tick(1'b0);
    chk_status("after_dealloc", 3, 1'b0, 1'b1);
    bus.dealloc_valid = 1'b0;
    #1;
    chk("retry_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    chk("retry_alloc_index", 64'(bus.alloc_index), 64'd2);
    exp_q.push_back('{idx: 2'd2, entry: 8'hC5});
    tick(1'b0);
    chk_status("refill", 4, 1'b1, 1'b1);
    bus.alloc_valid = 1'b0;

    // Modify a valid entry.
    bus.mod_valid = 1'b1;
    bus.mod_index = 2'd1;
    bus.mod_entry = 8'h5E;
    #1;
    chk("mod_ready", 64'(bus.mod_ready), 64'd1);
    exp_q.push_back('{idx: 2'd1, entry: 8'h5F});
    tick(1'b0);
    chk_status("mod", 4, 1'b1, 1'b1);
    chk("mod_perr", 64'(bus.proto_err), 64'd0);
    bus.mod_valid = 1'b0;

    // Free idx 3, then modify it: consumed, no write, sticky error.
    bus.dealloc_valid = 1'b1;
    bus.dealloc_index = 2'd3;
    exp_q.push_back('{idx: 2'd3, entry: 8'h00});
    tick(1'b0);
    bus.dealloc_valid = 1'b0;
    bus.mod_valid = 1'b1;
    bus.mod_index = 2'd3;
    bus.mod_entry = 8'h66;
    #1;
    chk("mod_inv_ready", 64'(bus.mod_ready), 64'd1);
    tick(1'b0);
    chk("mod_inv_perr", 64'(bus.proto_err), 64'd1);
    chk_status("mod_inv", 3, 1'b0, 1'b1);
    bus.mod_valid = 1'b0;
    // Dealloc of the same invalid entry: no write, no count change.
    bus.dealloc_valid = 1'b1;
    tick(1'b0);
    bus.dealloc_valid = 1'b0;
    tick(1'b0);
    chk("perr_sticky", 64'(bus.proto_err), 64'd1);
    chk_status("dealloc_inv", 3, 1'b0, 1'b1);

    // Free idx 0, allocate it back, then stall with the write pending.
    bus.dealloc_valid = 1'b1;
    bus.dealloc_index = 2'd0;
    exp_q.push_back('{idx: 2'd0, entry: 8'h00});
    tick(1'b0);
    bus.dealloc_valid = 1'b0;
    bus.alloc_valid = 1'b1;
    bus.alloc_entry = 8'h42;
    #1;
    chk("pre_hold_index", 64'(bus.alloc_index), 64'd0);
    exp_q.push_back('{idx: 2'd0, entry: 8'h43});
    tick(1'b0);
    enable = 1'b0;
    #1;
    chk("stall_alloc_ready", 64'(bus.alloc_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
    end
    chk_status("stall", 3, 1'b0, 1'b1);
    enable = 1'b1;
    bus.alloc_valid = 1'b0;
    tick(1'b0);
    chk_status("resume", 3, 1'b0, 1'b1);

    // Reset while a write is pending with occupancy 2.
    bus.dealloc_valid = 1'b1;
    bus.dealloc_index = 2'd0;
    exp_q.push_back('{idx: 2'd0, entry: 8'h00});
    tick(1'b0);
    bus.dealloc_valid = 1'b0;
    chk_status("pre_reset", 2, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async_rst");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Refill after reset from index 0, then hold alloc for 5 blocked cycles.
    for (int i = 0; i < 4; i++) begin
      ent = 8'h70 + 8'(i * 2);
      bus.alloc_valid = 1'b1;
      bus.alloc_entry = ent;
      #1;
      chk("post_rst_index", 64'(bus.alloc_index), 64'(i));
      exp_q.push_back('{idx: 2'(i), entry: ent | 8'h01});
      tick(1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("blocked_ready", 64'(bus.alloc_ready), 64'd0);
      tick(1'b0);
    end
    bus.alloc_valid = 1'b0;
    chk_status("stats", 4, 1'b1, 1'b1);
`ifdef L2_TSHR_ALLOC_STATS_EN
    chk("stall_cnt", 64'(bus.stall_cnt), 64'd5);
    chk("peak_occ", 64'(bus.peak_occ), 64'(DEPTH));
`else
    chk("stall_cnt_tied", 64'(bus.stall_cnt), 64'd0);
    chk("peak_occ_tied", 64'(bus.peak_occ), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
